// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front-end.
// Holds the default geometry of the image/kernel, the pixel word width
// and the state encoding of the pixel streamer FSM so that every block
// of the convolution path agrees on them.
package conv_pkg;

  // Pixel words are signed Q8.8.
  localparam int DATA_WIDTH_DEF  = 16;
  // Edge of the square convolution window.
  localparam int KERNEL_SIZE_DEF = 5;
  // Edge of the square input image.
  localparam int IMAGE_SIZE_DEF  = 28;
  // Frame-buffer address width, enough for IMAGE_SIZE**2 raster addresses.
  localparam int ADDR_W_DEF      = $clog2(IMAGE_SIZE_DEF * IMAGE_SIZE_DEF);

  // Frame sequencing states of the pixel streamer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } stream_state_t;

endpackage

// File: rtl/pixel_skid_buf.sv
// Output register plus one-entry skid register for the pixel stream.
// A word arriving while the consumer is stalled is parked in the skid
// register and is always emitted before any newer word.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   in_data         - incoming word (pixel plus sideband bits)
//   in_valid        - in_data is valid this cycle
//   stall           - consumer backpressure, high = do not emit
//   out_data        - emitted word; holds the last emitted word when write=0
//   write           - out_data is being emitted this cycle
module pixel_skid_buf #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             stall,
  output logic [WIDTH-1:0] out_data,
  output logic             write
);

  logic [WIDTH-1:0] head_data;
  logic             head_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic [WIDTH-1:0] held_data;
  logic             head_free;

  // The head word is offered every cycle but only counts as emitted when
  // the consumer is not stalling, so write drops in the same cycle as stall.
  assign write     = head_valid & ~stall;
  assign head_free = ~head_valid | ~stall;

  // Between emissions the output shows the previously emitted word rather
  // than whatever is waiting in the head register.
  assign out_data  = write ? head_data : held_data;

  // Head refills from the skid register first to keep ordering; a new
  // arrival while the head is blocked goes into the skid register. The
  // upstream fetcher never issues during stall, so the skid register is
  // always empty when such an arrival happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      held_data  <= '0;
    end else begin
      if (write) begin
        held_data <= head_data;
      end
      if (head_free) begin
        if (skid_valid) begin
          head_data  <= skid_data;
          head_valid <= 1'b1;
          skid_valid <= in_valid;
          if (in_valid) begin
            skid_data <= in_data;
          end
        end else begin
          head_valid <= in_valid;
          if (in_valid) begin
            head_data <= in_data;
          end
        end
      end else if (in_valid) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_streamer.sv
// Streams one IMAGE_SIZE x IMAGE_SIZE frame out of a frame buffer in raster
// order towards the line-buffer registers, flagging each pixel that
// completes a full KERNEL_SIZE x KERNEL_SIZE window.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   start           - frame request, only honoured while idle
//   stall           - downstream backpressure, high = do not emit
//   mem_rd_en       - frame-buffer read strobe
//   mem_addr        - raster read address row*IMAGE_SIZE+col
//   mem_rd_data     - read data, valid one cycle after mem_rd_en
//   write           - pixel_output strobe
//   pixel_output    - emitted pixel, unmodified frame-buffer data
//   window_valid    - emitted pixel completes a full window
//   busy            - frame in progress
//   done            - one-cycle end-of-frame pulse
module pixel_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF,
  parameter int ADDR_W      = $clog2(IMAGE_SIZE * IMAGE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] pixel_output,
  output logic                  window_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int                ROW_W     = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [ROW_W-1:0]  LAST_COL  = ROW_W'(IMAGE_SIZE - 1);
  localparam logic [ROW_W-1:0]  WIN_START = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE * IMAGE_SIZE - 1);

  stream_state_t         state_q;
  stream_state_t         state_d;
  logic                  clear_cnt;
  logic [ROW_W-1:0]      row_q;
  logic [ROW_W-1:0]      col_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  win_issue;
  logic                  rd_valid_q;
  logic                  rd_win_q;
  // Pixels read but not yet emitted: one in flight, head, skid.
  logic [2:0]            outstanding_q;
  logic [DATA_WIDTH:0]   skid_in;
  logic [DATA_WIDTH:0]   skid_out;

  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign win_issue = (row_q >= WIN_START) && (col_q >= WIN_START);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and read strobe. The flush finishes in the cycle the last
  // outstanding pixel is emitted so done follows the final write directly.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    clear_cnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_cnt = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!stall) begin
          mem_rd_en = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if ((outstanding_q == 3'd0) || ((outstanding_q == 3'd1) && write)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Raster counters. The linear address is kept alongside row/col so no
  // multiplier is needed; the counters stop on the last pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (clear_cnt) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (mem_rd_en && (addr_q != LAST_ADDR)) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (col_q == LAST_COL) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + ROW_W'(1);
      end
    end
  end

  // Tracks the read in flight so its window flag lines up with the data
  // that comes back one cycle later, and counts pixels not yet emitted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q    <= 1'b0;
      rd_win_q      <= 1'b0;
      outstanding_q <= 3'd0;
    end else begin
      rd_valid_q <= mem_rd_en;
      rd_win_q   <= win_issue;
      case ({mem_rd_en, write})
        2'b10:   outstanding_q <= outstanding_q + 3'd1;
        2'b01:   outstanding_q <= outstanding_q - 3'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // The window flag travels with the pixel through the skid/output pair.
  assign skid_in = {rd_win_q, mem_rd_data};

  pixel_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (skid_in),
    .in_valid (rd_valid_q),
    .stall    (stall),
    .out_data (skid_out),
    .write    (write)
  );

  assign pixel_output = skid_out[DATA_WIDTH-1:0];
  assign window_valid = write & skid_out[DATA_WIDTH];

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: a frame-buffer model answers
// reads one cycle later, a scoreboard queue holds the pixels each frame
// should emit, and one task per scenario compares the captured stream.
module tb_pixel_streamer;

  localparam int IMG  = 28;
  localparam int K    = 5;
  localparam int NPIX = IMG * IMG;
  localparam int NWIN = (IMG - K + 1) * (IMG - K + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rd_data = 16'h0;
  logic        write;
  logic [15:0] pixel_output;
  logic        window_valid;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:1023];
  int          cyc = 0;

  int          checks = 0;
  int          errors = 0;

  logic [15:0] exp_pix[$];
  bit          exp_win[$];
  logic [15:0] got_pix[$];
  bit          got_win[$];
  int          got_cyc[$];
  int          done_cyc[$];
  int          start_cyc;
  int          stall_writes;
  int          stall_reads;
  int          busy_gaps;
  bit          timed_out;
  bit          aborted;

  pixel_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .write        (write),
    .pixel_output (pixel_output),
    .window_valid (window_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer with one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic fill_ramp();
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i << 8);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  // Expected output stream of one frame, raster order.
  task automatic load_scoreboard();
    exp_pix.delete();
    exp_win.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_pix.push_back(mem[i]);
      exp_win.push_back(((i / IMG) >= K - 1) && ((i % IMG) >= K - 1));
    end
  endtask

  // Runs one frame and records every write. stall_addr >= 0 stalls three
  // cycles right after that address is read; restart_at / reset_at fire a
  // start pulse / reset once that many pixels have been written.
  task automatic applyStimulus(input int stall_addr, input int restart_at, input int reset_at);
    int stall_left = 0;
    int extra = -1;
    bit restarted = 1'b0;
    got_pix.delete(); got_win.delete(); got_cyc.delete(); done_cyc.delete();
    stall_writes = 0; stall_reads = 0; busy_gaps = 0; timed_out = 1'b0; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    stall = 1'b0;
    start_cyc = cyc;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_at >= 0 && !restarted && got_pix.size() == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (reset_at >= 0 && got_pix.size() == reset_at) begin
        reset = 1'b0;
        #1;
        aborted = 1'b1;
        return;
      end
      stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (write) begin
        got_pix.push_back(pixel_output);
        got_win.push_back(window_valid);
        got_cyc.push_back(cyc);
        if (stall) stall_writes++;
      end
      if (stall && mem_rd_en) stall_reads++;
      if (done) done_cyc.push_back(cyc);
      if (!busy && done_cyc.size() == 0) busy_gaps++;
      if (stall_addr >= 0 && mem_rd_en && int'(mem_addr) == stall_addr) stall_left = 3;
      if (done_cyc.size() > 0 && extra < 0) extra = 4;
      if (extra == 0) break;
      if (extra > 0) extra--;
    end
    stall = 1'b0;
    start = 1'b0;
    if (done_cyc.size() == 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({mem_rd_en, mem_addr, write, pixel_output, window_valid, busy, done} !== 31'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d got rd=%b addr=%0d wr=%b pix=%h win=%b busy=%b done=%b want all 0",
                 i, mem_rd_en, mem_addr, write, pixel_output, window_valid, busy, done);
      end
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_ramp();
    logic [15:0] ep;
    bit ew;
    fill_ramp();
    load_scoreboard();
    applyStimulus(-1, -1, -1);
    checks++;
    if (timed_out) begin errors++; $display("[TB] FAIL ramp_timeout got no done want done"); end
    checks++;
    if (got_pix.size() != NPIX) begin
      errors++; $display("[TB] FAIL ramp_count got %0d want %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && exp_pix.size() > 0; i++) begin
      ep = exp_pix.pop_front();
      ew = exp_win.pop_front();
      checks++;
      if ({got_win[i], got_pix[i]} !== {ew, ep}) begin
        errors++; $display("[TB] FAIL ramp_pix[%0d] got %h/%b want %h/%b", i, got_pix[i], got_win[i], ep, ew);
      end
    end
    if (got_pix.size() > 0) begin
      checks++;
      if (got_cyc[0] != start_cyc + 3) begin
        errors++; $display("[TB] FAIL ramp_first_write got cycle %0d want %0d", got_cyc[0], start_cyc + 3);
      end
      checks++;
      if (got_cyc[got_cyc.size()-1] - got_cyc[0] != NPIX - 1) begin
        errors++; $display("[TB] FAIL ramp_consecutive got span %0d want %0d",
                           got_cyc[got_cyc.size()-1] - got_cyc[0], NPIX - 1);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != got_cyc[got_cyc.size()-1] + 1) begin
        errors++; $display("[TB] FAIL ramp_done got %0d pulses first at %0d want 1 at %0d",
                           done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, got_cyc[got_cyc.size()-1] + 1);
      end
    end
    checks++;
    if (busy_gaps != 0) begin errors++; $display("[TB] FAIL ramp_busy got %0d idle cycles want 0", busy_gaps); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ramp_busy_after got %b want 0", busy); end
  endtask

  task automatic test_windows();
    int nwin = 0;
    int first = -1;
    int early_col = 0;
    fill_ramp();
    applyStimulus(-1, -1, -1);
    for (int i = 0; i < got_win.size(); i++) begin
      if (got_win[i]) begin
        nwin++;
        if (first < 0) first = i;
        if ((i % IMG) < K - 1) early_col++;
      end
    end
    checks++;
    if (nwin != NWIN) begin errors++; $display("[TB] FAIL win_count got %0d want %0d", nwin, NWIN); end
    checks++;
    if (first != (K - 1) * IMG + (K - 1)) begin
      errors++; $display("[TB] FAIL win_first got %0d want %0d", first, (K - 1) * IMG + (K - 1));
    end
    checks++;
    if (early_col != 0) begin errors++; $display("[TB] FAIL win_low_cols got %0d want 0", early_col); end
  endtask

  task automatic test_stall();
    logic [15:0] ep;
    bit ew;
    fill_ramp();
    load_scoreboard();
    applyStimulus(50, -1, -1);
    checks++;
    if (got_pix.size() != NPIX) begin
      errors++; $display("[TB] FAIL stall_count got %0d want %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && exp_pix.size() > 0; i++) begin
      ep = exp_pix.pop_front();
      ew = exp_win.pop_front();
      checks++;
      if ({got_win[i], got_pix[i]} !== {ew, ep}) begin
        errors++; $display("[TB] FAIL stall_pix[%0d] got %h/%b want %h/%b", i, got_pix[i], got_win[i], ep, ew);
      end
    end
    checks++;
    if (stall_writes != 0) begin errors++; $display("[TB] FAIL stall_write got %0d writes want 0", stall_writes); end
    checks++;
    if (stall_reads != 0) begin errors++; $display("[TB] FAIL stall_read got %0d reads want 0", stall_reads); end
    if (got_cyc.size() > 0) begin
      checks++;
      if (got_cyc[got_cyc.size()-1] - got_cyc[0] != NPIX - 1 + 3) begin
        errors++; $display("[TB] FAIL stall_span got %0d want %0d", got_cyc[got_cyc.size()-1] - got_cyc[0], NPIX + 2);
      end
    end
  endtask

  task automatic test_stall_flush_random();
    logic [15:0] ep;
    bit ew;
    fill_random();
    load_scoreboard();
    applyStimulus(NPIX - 1, -1, -1);
    checks++;
    if (got_pix.size() != NPIX) begin
      errors++; $display("[TB] FAIL rnd_count got %0d want %0d", got_pix.size(), NPIX);
    end
    for (int i = 0; i < got_pix.size() && exp_pix.size() > 0; i++) begin
      ep = exp_pix.pop_front();
      ew = exp_win.pop_front();
      checks++;
      if ({got_win[i], got_pix[i]} !== {ew, ep}) begin
        errors++; $display("[TB] FAIL rnd_pix[%0d] got %h/%b want %h/%b", i, got_pix[i], got_win[i], ep, ew);
      end
    end
    if (got_cyc.size() > 0) begin
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != got_cyc[got_cyc.size()-1] + 1) begin
        errors++; $display("[TB] FAIL rnd_done got %0d pulses first at %0d want 1 at %0d",
                           done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, got_cyc[got_cyc.size()-1] + 1);
      end
    end
    checks++;
    if (stall_writes != 0) begin errors++; $display("[TB] FAIL rnd_stall_write got %0d want 0", stall_writes); end
  endtask

  task automatic test_start_busy();
    logic [15:0] ep;
    bit ew;
    fill_ramp();
    load_scoreboard();
    applyStimulus(-1, 300, -1);
    checks++;
    if (got_pix.size() != NPIX) begin
      errors++; $display("[TB] FAIL busy_start_count got %0d want %0d", got_pix.size(), NPIX);
    end
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("[TB] FAIL busy_start_done got %0d want 1", done_cyc.size()); end
    for (int i = 0; i < got_pix.size() && exp_pix.size() > 0; i++) begin
      ep = exp_pix.pop_front();
      ew = exp_win.pop_front();
      checks++;
      if ({got_win[i], got_pix[i]} !== {ew, ep}) begin
        errors++; $display("[TB] FAIL busy_start_pix[%0d] got %h/%b want %h/%b", i, got_pix[i], got_win[i], ep, ew);
      end
    end
  endtask

  task automatic test_mid_reset();
    fill_ramp();
    applyStimulus(-1, -1, 200);
    checks++;
    if (!aborted) begin errors++; $display("[TB] FAIL midrst_reached got no reset want reset at pixel 200"); end
    checks++;
    if ({mem_rd_en, mem_addr, write, pixel_output, window_valid, busy, done} !== 31'd0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs got rd=%b addr=%0d wr=%b pix=%h win=%b busy=%b done=%b want all 0",
               mem_rd_en, mem_addr, write, pixel_output, window_valid, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NPIX; i++) mem[i] = 16'(16'hA000 + i);
    applyStimulus(-1, -1, -1);
    checks++;
    if (got_pix.size() == 0 || got_pix[0] !== 16'hA000) begin
      errors++; $display("[TB] FAIL midrst_first got %h want a000", (got_pix.size() > 0) ? got_pix[0] : 16'hxxxx);
    end
    checks++;
    if (got_pix.size() != NPIX) begin
      errors++; $display("[TB] FAIL midrst_count got %0d want %0d", got_pix.size(), NPIX);
    end
    checks++;
    if (got_pix.size() == NPIX && got_pix[NPIX-1] !== 16'(16'hA000 + NPIX - 1)) begin
      errors++; $display("[TB] FAIL midrst_last got %h want %h", got_pix[NPIX-1], 16'(16'hA000 + NPIX - 1));
    end
  endtask

  task automatic checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_windows();
    test_stall();
    test_stall_flush_random();
    test_start_busy();
    test_mid_reset();
    checkOutput();
    $finish;
  end

endmodule
